// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Definitions shared by the UART transmitter and receiver.
//   - uart_tx_state_t : transmitter frame state
//   - baud_div()      : clocks per bit; both directions call this one function
//                       so their bit timing always matches.
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  // Integer division; any remainder shows up as a small rate error on the line.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
//   Parallel word handshake into the UART transmitter.
//   - tx_data  : word to send, sampled only on the accept edge
//   - tx_valid : producer has a word
//   - tx_ready : transmitter can accept a word (idle)
//   A word moves on a rising clk edge with tx_valid && tx_ready.
// -----------------------------------------------------------------------------
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
//   Bit-period timer. Counts 0..DIVIDER-1 while enabled and pulses tick on the
//   last count (the cycle the count wraps). Held at 0 while disabled, so the
//   first bit period after enable rises is always exactly DIVIDER cycles.
//   Ports:
//   - clk    : system clock
//   - reset  : synchronous, active-high
//   - enable : run the counter
//   - tick   : one-cycle pulse at the end of each bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int DIVIDER = 868
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVIDER - 1);

  logic [CW-1:0] count_q;

  assign tick = enable && (count_q == LAST);

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      count_q <= '0;
    end else if (tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   Asynchronous serial transmitter: start bit, DATA_BITS data bits LSB-first,
//   STOP_BITS stop bits, no parity. Line idles high.
//   Ports:
//   - clk        : system clock, all logic on the rising edge
//   - reset      : synchronous, active-high; aborts any frame in progress
//   - tx_if      : word handshake (slave side); tx_ready is high only in IDLE
//   - tx_line    : registered serial output
//   - busy       : a frame is in progress (state is not IDLE)
//   - frame_done : one-cycle pulse during the last clock of the final stop bit
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 115_200,
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 1
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  tx_if,
  output logic      tx_line,
  output logic      busy,
  output logic      frame_done
);

  localparam int BAUD_DIVIDER = baud_div(CLK_FREQUENCY, BAUD_RATE);
  localparam int BCW          = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  if (BAUD_DIVIDER < 2) begin : g_bad_divider
    $error("uart_tx: CLK_FREQUENCY/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  uart_tx_state_t       state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 line_q, line_d;
  logic                 tick;

  uart_baud_gen #(
    .DIVIDER (BAUD_DIVIDER)
  ) u_baud_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (busy),
    .tick   (tick)
  );

  assign busy           = (state_q != IDLE);
  assign tx_if.tx_ready = (state_q == IDLE);
  assign tx_line        = line_q;

  // Decoded from registered state and the registered baud count, so it is
  // aligned exactly with the last stop-bit clock without a look-ahead counter.
  assign frame_done = (state_q == STOP) && tick && (bit_cnt_q == LAST_STOP);

  // The bit counter is reused: data bits in DATA, stop bits in STOP.
  // line_d always carries the value the line must show in the next state, so
  // tx_line stays a plain flop with no decode after it.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // and no latch is inferred.
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    line_d    = line_q;

    case (state_q)
      IDLE: begin
        line_d = 1'b1;
        // tx_ready is high in every IDLE cycle, so tx_valid alone accepts.
        if (tx_if.tx_valid) begin
          shift_d   = tx_if.tx_data;
          bit_cnt_d = '0;
          line_d    = 1'b0;
          state_d   = START;
        end
      end

      START: begin
        if (tick) begin
          line_d  = shift_q[0];
          state_d = DATA;
        end
      end

      DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = '0;
            line_d    = 1'b1;
            state_d   = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            line_d    = shift_q[1];
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (bit_cnt_q == LAST_STOP) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge values
    // regardless of statement order.
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      line_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      line_q    <= line_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Bench for uart_tx. dut0: divider 10, 8N1. dut1: divider 10, 7 data bits,
//   2 stop bits. dut0 words are pushed to a scoreboard queue on acceptance and
//   popped by a mid-bit sampling receiver model watching tx_line.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  logic clk;
  logic reset;

  logic line0, busy0, fd0;
  logic line1, busy1, fd1;

  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(7)) if1 ();

  uart_tx #(
    .CLK_FREQUENCY (100_000_000),
    .BAUD_RATE     (10_000_000),
    .DATA_BITS     (8),
    .STOP_BITS     (1)
  ) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .tx_if      (if0),
    .tx_line    (line0),
    .busy       (busy0),
    .frame_done (fd0)
  );

  uart_tx #(
    .CLK_FREQUENCY (100_000_000),
    .BAUD_RATE     (10_000_000),
    .DATA_BITS     (7),
    .STOP_BITS     (2)
  ) u_dut1 (
    .clk        (clk),
    .reset      (reset),
    .tx_if      (if1),
    .tx_line    (line1),
    .busy       (busy1),
    .frame_done (fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [7:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // {tx_line, frame_done, tx_ready, busy} when idle
  task automatic check_idle0(input string name);
    check(name, {line0, fd0, if0.tx_ready, busy0}, 4'b1010);
  endtask

  // Wait for ready, present the word for one accept edge. Returns at #1 after
  // the accept edge E, i.e. in cycle E+1.
  task automatic send0(input logic [7:0] d, input bit hold);
    int n;
    n = 0;
    while (if0.tx_ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (if0.tx_ready !== 1'b1) check("ready_timeout", {31'd0, if0.tx_ready}, 1);
    if0.tx_data  = d;
    if0.tx_valid = 1'b1;
    sb_q.push_back(d);
    @(posedge clk); #1;
    if (!hold) if0.tx_valid = 1'b0;
  endtask

  // Called in cycle E+1; checks cycles E+1..E+100 and returns in cycle E+101.
  // pat[i] is the i-th bit on the line (start, d0..d7, stop).
  task automatic check_frame0(input logic [9:0] pat, input string name, input bit disturb);
    for (int k = 1; k <= 100; k++) begin
      check($sformatf("%s_k%0d", name, k), {line0, fd0, if0.tx_ready, busy0},
            {pat[(k-1)/10], (k == 100), 1'b0, 1'b1});
      if (disturb && k == 30) begin
        if0.tx_data  = 8'h12;
        if0.tx_valid = 1'b1;
      end
      if (disturb && k == 50) if0.tx_valid = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  // Receiver model: start detected at a negedge with the line low (c=0),
  // then every value is taken in the middle of its bit.
  initial begin : rx_model
    logic [7:0] word;
    bit abort;
    forever begin
      @(negedge clk);
      if (!reset && line0 === 1'b0) begin
        abort = 1'b0;
        word  = '0;
        for (int c = 1; c <= 95 && !abort; c++) begin
          @(negedge clk);
          if (reset) abort = 1'b1;
          else if (c == 5) check("rx_start_bit", {31'd0, line0}, 0);
          else if (c >= 15 && c <= 85 && (c - 15) % 10 == 0) word[(c-15)/10] = line0;
          else if (c == 95) begin
            check("rx_stop_bit", {31'd0, line0}, 1);
            if (sb_q.size() == 0) check("rx_sb_size", sb_q.size(), 1);
            else check("rx_word", word, sb_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [7:0] data;
    logic [9:0] pat;
    string      name;
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    vecs[0] = '{data: 8'h55, pat: 10'h2AA, name: "f55"};
    vecs[1] = '{data: 8'hA3, pat: 10'h346, name: "fA3"};
    vecs[2] = '{data: 8'h00, pat: 10'h200, name: "f00"};
    vecs[3] = '{data: 8'hFF, pat: 10'h3FE, name: "fFF"};
    vecs[4] = '{data: 8'h3C, pat: 10'h278, name: "f3C"};

    reset        = 1'b1;
    if0.tx_valid = 1'b0;
    if0.tx_data  = '0;
    if1.tx_valid = 1'b0;
    if1.tx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check_idle0("reset_dut0");
    check("reset_dut1", {line1, fd1, if1.tx_ready, busy1}, 4'b1010);

    // Table-driven single frames (also the loopback words A3, 00, FF)
    for (int i = 0; i < 5; i++) begin
      send0(vecs[i].data, 1'b0);
      check_frame0(vecs[i].pat, vecs[i].name, 1'b0);
      check_idle0({vecs[i].name, "_idle"});
      repeat (3) @(posedge clk);
      #1;
    end

    // Back-to-back with tx_valid held: one IDLE cycle between frames
    send0(8'h00, 1'b1);
    if0.tx_data = 8'hFF;
    check_frame0(10'h200, "b2b0", 1'b0);
    check_idle0("b2b_gap");
    sb_q.push_back(8'hFF);
    @(posedge clk); #1;
    if0.tx_valid = 1'b0;
    check_frame0(10'h3FE, "b2b1", 1'b0);
    check_idle0("b2b_end");

    // Data change and valid pulse while busy are ignored
    repeat (2) @(posedge clk);
    #1;
    send0(8'hA5, 1'b0);
    check_frame0(10'h34A, "chg", 1'b1);
    for (int k = 0; k < 20; k++) begin
      check_idle0($sformatf("chg_noframe_%0d", k));
      @(posedge clk); #1;
    end

    // tx_valid and reset on the same edge: nothing accepted
    if0.tx_data  = 8'h99;
    if0.tx_valid = 1'b1;
    reset        = 1'b1;
    @(posedge clk); #1;
    if0.tx_valid = 1'b0;
    reset        = 1'b0;
    check_idle0("rst_valid_0");
    @(posedge clk); #1;
    check_idle0("rst_valid_1");

    // Reset mid data bit 2 aborts the frame
    send0(8'h55, 1'b0);
    for (int k = 1; k <= 34; k++) begin
      @(posedge clk); #1;
    end
    // now in cycle E+35
    check("abort_before", {line0, busy0}, {1'b1, 1'b1});
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    void'(sb_q.pop_back());
    @(posedge clk); #1;
    check_idle0("abort_e37");
    send0(8'h3C, 1'b0);
    check_frame0(10'h278, "after_rst", 1'b0);
    check_idle0("after_rst_idle");

    // 7 data bits, 2 stop bits, word 0x7F: 10 low cycles then 90 high
    if1.tx_data  = 7'h7F;
    if1.tx_valid = 1'b1;
    @(posedge clk); #1;
    if1.tx_valid = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      check($sformatf("s2_k%0d", k), {line1, fd1, if1.tx_ready, busy1},
            {(k > 10), (k == 100), 1'b0, 1'b1});
      @(posedge clk); #1;
    end
    check("s2_idle", {line1, fd1, if1.tx_ready, busy1}, 4'b1010);

    repeat (20) @(posedge clk);
    #1;
    check("sb_empty", sb_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter: accepts parallel words over a valid/ready handshake and drives an 8N1-style asynchronous frame (start bit, DATA_BITS data bits LSB-first, STOP_BITS stop bits) onto a single line. It is the upstream counterpart of the receiver. Its `tx_line` connects directly, or through the board pin, to the receiver's `received_bit`, and it uses the same baud-divider arithmetic.

## Interface
- `CLK_FREQUENCY`, 100_000_000: system clock in Hz.
- `BAUD_RATE`, 115_200: line bit rate in bits/s.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.
- `clk`, input, 1: system clock; all logic on rising edge.
- `reset`, input, 1: synchronous, active-high.
- `tx_data`, input, DATA_BITS: word to send; sampled only on the accept edge.
- `tx_valid`, input, 1: producer has a word.
- `tx_ready`, output, 1: block can accept a word; high only in IDLE.
- `tx_line`, output, 1: serial output, registered, idle-high.
- `busy`, output, 1: high whenever state is not IDLE.
- `frame_done`, output, 1: single-cycle pulse during the last clock of the final stop bit.

## Operation
- `baud_divider = CLK_FREQUENCY / BAUD_RATE`, using integer division.
  - Elaboration-time assertion: `baud_divider >= 2`.
  - Elaboration-time assertion: `DATA_BITS` and `STOP_BITS` are within their legal ranges.
- Baud counter width is `$clog2(baud_divider)`. It counts 0..`baud_divider-1`, then wraps. It is held at 0 in IDLE.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - `tx_line=1`, `tx_ready=1`.
  - When `tx_valid && tx_ready`: latch `tx_data` into the shift register, clear the bit counter, and go to START.
- START:
  - `tx_line=0` for `baud_divider` cycles, then go to DATA.
- DATA:
  - `tx_line` = shift register bit 0. The register shifts right once per bit period.
  - The bit counter (width `$clog2(DATA_BITS+1)`) increments per bit.
  - After `DATA_BITS` periods, clear the bit counter and go to STOP.
- STOP:
  - `tx_line=1` for `STOP_BITS*baud_divider` cycles.
  - `frame_done` pulses on the final cycle, then go to IDLE.
- `tx_data` and `tx_valid` changes outside the accept edge are ignored. The latched word is immune to input changes mid-frame.
- No parity. No break generation.

## Timing
- Reset values (cycle after a reset edge):
  - state IDLE
  - `tx_line=1`, `tx_ready=1`, `busy=0`, `frame_done=0`
  - counters 0, shift register 0
- Reset during a frame aborts it immediately. `tx_line` returns high on the next cycle and the word is discarded.
- Accept edge E: `tx_line` is low from cycle E+1. Each bit lasts exactly `baud_divider` cycles.
- Frame length from E+1 to the return to IDLE: `(1+DATA_BITS+STOP_BITS)*baud_divider` cycles.
- `frame_done` is high in cycle `E + (1+DATA_BITS+STOP_BITS)*baud_divider`.
- `tx_ready` rises in the cycle after `frame_done`.
- Back-to-back (`tx_valid` held high): exactly one IDLE cycle between frames. Minimum high time between frames is `STOP_BITS*baud_divider + 1` cycles. The receiver tolerates this.
- `tx_valid` asserted while not IDLE: no effect. The producer must hold `tx_valid` and `tx_data` until it sees `tx_ready` high at an edge.
- `tx_valid` and `reset` on the same edge: reset wins and nothing is accepted.

## Structure
- Shared package `uart_pkg` holds:
  - the `uart_tx_state_t` enum (IDLE, START, DATA, STOP)
  - the function `baud_div(clk_hz, baud)` used by both TX and RX, so the divider rule stays identical.
- One natural sub-module, `uart_baud_gen`:
  - Parameter `DIVIDER`; inputs `clk`, `reset`, `enable`; output `tick`.
  - `tick` pulses on the count wrap; the count is held at 0 when `enable=0`.
  - The TX instantiates it with `enable = busy`.
- Everything else stays in `uart_tx`.

## Test plan
All scenarios use `CLK_FREQUENCY=100_000_000`, `BAUD_RATE=10_000_000` (divider 10), `DATA_BITS=8`, `STOP_BITS=1` unless noted.
- Single frame: send 0x55.
  - `tx_line` is 0 for 10 cycles, then 1,0,1,0,1,0,1,0 for 10 cycles each, then 1 for 10.
  - `frame_done` is high at E+100; `tx_ready` rises at E+101.
- Back-to-back: hold `tx_valid` with 0x00 then 0xFF.
  - Second start bit begins exactly 11 high cycles after the last data bit of frame 1.
  - Frame 2 data bits are all 1.
- Stimulus change mid-frame: change `tx_data` to 0x12 during frame 1 and pulse `tx_valid` while busy. Frame carries 0xA5 and no second frame starts.
- Reset at E+35 (mid data bit 2): `tx_line=1` and `tx_ready=1` at E+37. A new frame with 0x3C then transmits correctly.
- `STOP_BITS=2`, `DATA_BITS=7`, send 0x7F: frame is 100 cycles, with 20 stop cycles at the end.
- Loopback with the receiver (same parameters): send 0xA3, 0x00, 0xFF. Receiver `processed_data` matches each word in order.
